// File: rtl/xor_accumulator_pkg.sv
// Shared types and helpers for the xor_accumulator packet checksum engine.
// XOR_ACC_ROTATE_EN (optional) selects the order-sensitive rotate-and-XOR accumulation.
package xor_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_LANES   = 2;
    localparam int unsigned DEF_COUNT_W = 8;
    localparam int unsigned DEF_IN_W    = DEF_WIDTH * DEF_LANES;

    // rol1 works on a fixed-size container; only the low w bits are meaningful.
    localparam int unsigned ROL_MAX_W = 64;

    function automatic logic [ROL_MAX_W-1:0] rol1(input logic [ROL_MAX_W-1:0] v,
                                                  input int unsigned           w);
        logic [ROL_MAX_W-1:0] mask;
        mask = {ROL_MAX_W{1'b1}} >> (ROL_MAX_W - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/xor_accumulator_if.sv
// Input-beat and result streams of xor_accumulator, each a valid/ready handshake.
interface xor_accumulator_if
    import xor_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [COUNT_W-1:0]       out_count;
    logic                     out_parity;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_parity
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_parity
    );

endinterface

// File: rtl/xor_accumulator_xor_reduce.sv
// Combinational XOR reduction of LANES packed WIDTH-bit lanes into one lane.
module xor_reduce
    import xor_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic [LANES*WIDTH-1:0] data,
    output logic [WIDTH-1:0]       result
);

    always_comb begin
        result = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            result = result ^ data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/xor_accumulator.sv
// Packet checksum/parity engine: XOR-reduces beats into an accumulator, reports on last beat.
// Optional macro XOR_ACC_ROTATE_EN: rotate the accumulator left by one before each XOR.
module xor_accumulator
    import xor_acc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned COUNT_W = DEF_COUNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    xor_accumulator_if.slave  bus
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_next, lane_xor;
    logic [COUNT_W-1:0] cnt_q, cnt_d, cnt_next;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [COUNT_W-1:0] out_count_q, out_count_d;
    logic               out_parity_q, out_parity_d;
    logic               accept;

    xor_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .data   (bus.in_data),
        .result (lane_xor)
    );

    assign bus.in_ready = (state_q != HOLD);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
`ifdef XOR_ACC_ROTATE_EN
        acc_next = WIDTH'(rol1(ROL_MAX_W'(acc_q), WIDTH)) ^ lane_xor;
`else
        acc_next = acc_q ^ lane_xor;
`endif
        cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_parity_d = out_parity_q;

        if (clear) begin
            state_d      = IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_count_d  = '0;
            out_parity_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d = acc_next;
                        cnt_d = cnt_next;
                        if (bus.in_last) begin
                            // Result registers load from the same values being accumulated.
                            state_d      = HOLD;
                            out_valid_d  = 1'b1;
                            out_data_d   = acc_next;
                            out_count_d  = cnt_next;
                            out_parity_d = ^acc_next;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_parity_q <= out_parity_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_count  = out_count_q;
    assign bus.out_parity = out_parity_q;

endmodule

// File: tb/tb_xor_accumulator.sv
// Scoreboard bench for xor_accumulator: COUNT_W=8 and COUNT_W=2 instances share one stimulus stream.
// Honours XOR_ACC_ROTATE_EN so the reference model matches the selected build.
module tb_xor_accumulator;

    typedef struct {
        logic [15:0] data;
        int unsigned cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        ready_mode;
    logic        forced_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] pkt[$];
    exp_t        exp8[$];
    exp_t        exp2[$];

    xor_accumulator_if #(.WIDTH(16), .LANES(2), .COUNT_W(8)) bus8 ();
    xor_accumulator_if #(.WIDTH(16), .LANES(2), .COUNT_W(2)) bus2 ();

    assign bus8.in_valid  = in_valid;
    assign bus8.in_data   = in_data;
    assign bus8.in_last   = in_last;
    assign bus8.out_ready = out_ready;
    assign bus2.in_valid  = in_valid;
    assign bus2.in_data   = in_data;
    assign bus2.in_last   = in_last;
    assign bus2.out_ready = out_ready;

    xor_accumulator #(.WIDTH(16), .LANES(2), .COUNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus8)
    );

    xor_accumulator #(.WIDTH(16), .LANES(2), .COUNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: checksum computed over the whole packet once its last beat is taken.
    task automatic model_accept(input logic [15:0] l0, input logic [15:0] l1, input logic last);
        logic [15:0] c;
        exp_t        e;
        pkt.push_back({l1, l0});
        if (last) begin
            c = 16'h0000;
            foreach (pkt[i]) begin
`ifdef XOR_ACC_ROTATE_EN
                c = {c[14:0], c[15]};
`endif
                c = c ^ pkt[i][15:0] ^ pkt[i][31:16];
            end
            e.data = c;
            e.cnt  = pkt.size();
            exp8.push_back(e);
            exp2.push_back(e);
            pkt.delete();
        end
    endtask

    task automatic model_flush();
        pkt.delete();
        exp8.delete();
        exp2.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] l0, input logic [15:0] l1, input logic last);
        int unsigned waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_last  = last;
        @(negedge clk);
        while (!bus8.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus8.in_ready) begin
            check("accept_timeout", 64'(bus8.in_ready), 64'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            next_cycle();
            return;
        end
        @(posedge clk);
        model_accept(l0, l1, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) check("result_latency", 64'(bus8.out_valid), 64'd1);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = ready_mode ? 1'($urandom_range(0, 1)) : forced_ready;
        end
    end

    // Monitors: compare against the queue head every cycle a result is shown, pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus8.out_valid) begin
                if (exp8.size() == 0) begin
                    check("unexpected_result8", 64'(bus8.out_valid), 64'd0);
                end else begin
                    e = exp8[0];
                    check("out_data8", 64'(bus8.out_data), 64'(e.data));
                    check("out_count8", 64'(bus8.out_count), 64'((e.cnt > 255) ? 255 : e.cnt));
                    check("out_parity8", 64'(bus8.out_parity), 64'(^e.data));
                    if (bus8.out_ready) exp8.delete(0);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus2.out_valid) begin
                if (exp2.size() == 0) begin
                    check("unexpected_result2", 64'(bus2.out_valid), 64'd0);
                end else begin
                    e = exp2[0];
                    check("out_data2", 64'(bus2.out_data), 64'(e.data));
                    check("out_count2", 64'(bus2.out_count), 64'((e.cnt > 3) ? 3 : e.cnt));
                    check("out_parity2", 64'(bus2.out_parity), 64'(^e.data));
                    if (bus2.out_ready) exp2.delete(0);
                end
            end
        end
    end

    initial begin
        int unsigned waited;
        int unsigned len;
        reset        = 1'b0;
        clear        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        ready_mode   = 1'b0;
        forced_ready = 1'b1;

        #1 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_out_data", 64'(bus8.out_data), 64'd0);
        check("rst_out_count", 64'(bus8.out_count), 64'd0);
        check("rst_out_parity", 64'(bus8.out_parity), 64'd0);
        #10 reset = 1'b0;
        next_cycle();

        // Two-beat and single-beat packets
        send_beat(16'h00FF, 16'h0F0F, 1'b0);
        send_beat(16'h1234, 16'h0000, 1'b1);
        next_cycle();
        send_beat(16'h5555, 16'hAAAA, 1'b1);
        next_cycle();

        // Backpressure: result held three cycles while a beat waits
        forced_ready = 1'b0;
        next_cycle();
        send_beat(16'h1111, 16'h2222, 1'b1);
        in_valid = 1'b1;
        in_data  = {16'h00F0, 16'h0F00};
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus8.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus8.out_valid), 64'd1);
        end
        next_cycle();
        forced_ready = 1'b1;
        send_beat(16'h0F00, 16'h00F0, 1'b1);
        next_cycle();

        // Clear mid-packet, discarding a last beat presented alongside it
        send_beat(16'hBEEF, 16'h1234, 1'b0);
        in_valid = 1'b1;
        in_data  = {16'hFFFF, 16'h8000};
        in_last  = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        pkt.delete();
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_mid_out_valid", 64'(bus8.out_valid), 64'd0);
        check("clr_mid_in_ready", 64'(bus8.in_ready), 64'd1);
        send_beat(16'h0001, 16'h0000, 1'b1);
        next_cycle();

        // Clear while the result is held
        forced_ready = 1'b0;
        next_cycle();
        send_beat(16'hCAFE, 16'h0101, 1'b1);
        next_cycle();
        check("hold_out_valid", 64'(bus8.out_valid), 64'd1);
        clear = 1'b1;
        @(posedge clk);
        exp8.delete(0);
        exp2.delete(0);
        #1;
        clear = 1'b0;
        check("clr_hold_out_valid", 64'(bus8.out_valid), 64'd0);
        check("clr_hold_in_ready", 64'(bus8.in_ready), 64'd1);
        forced_ready = 1'b1;
        send_beat(16'h0001, 16'h0000, 1'b1);
        next_cycle();

        // Five-beat packet saturates the 2-bit counter
        for (int b = 0; b < 5; b++) send_beat(16'(b * 3 + 1), 16'(b << 8), b == 4);
        next_cycle();

        // Async reset mid-packet, then in HOLD
        send_beat(16'h7777, 16'h3333, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("areset_mid_in_ready", 64'(bus8.in_ready), 64'd1);
        check("areset_mid_out_valid", 64'(bus8.out_valid), 64'd0);
        model_flush();
        #1 reset = 1'b0;
        next_cycle();
        send_beat(16'h4242, 16'h0404, 1'b1);
        next_cycle();
        forced_ready = 1'b0;
        next_cycle();
        send_beat(16'h9999, 16'h6666, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("areset_hold_in_ready", 64'(bus8.in_ready), 64'd1);
        check("areset_hold_out_valid", 64'(bus8.out_valid), 64'd0);
        check("areset_hold_out_count", 64'(bus8.out_count), 64'd0);
        model_flush();
        #1 reset = 1'b0;
        forced_ready = 1'b1;
        next_cycle();

        // Randomized packets with gaps and random backpressure
        ready_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < int'(len); b++) begin
                repeat ($urandom_range(0, 2)) next_cycle();
                send_beat(16'($urandom), 16'($urandom), b == int'(len) - 1);
            end
        end

        ready_mode   = 1'b0;
        forced_ready = 1'b1;
        waited = 0;
        while ((exp8.size() != 0 || exp2.size() != 0) && waited < 20) begin
            next_cycle();
            waited++;
        end
        check("drain8", 64'(exp8.size()), 64'd0);
        check("drain2", 64'(exp2.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
